// File: rtl/sram_dp.sv
// Dual-port synchronous SRAM: read-only instruction port plus byte-enabled
// read/write data port, registered one-cycle reads, optional post-reset zero-fill.
module sram_dp #(
  parameter int ADDR           = 8,
  parameter int WIDTH          = 32,
  parameter int LENGTH         = 256,
  parameter     INIT_FILE      = "",
  parameter int CLEAR_ON_RESET = 0,
  parameter int WRITE_FIRST    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  input  logic [ADDR-1:0]    i_addr,
  output logic [WIDTH-1:0]   instruction,
  output logic               i_valid,
  input  logic               CS,
  input  logic               WE,
  input  logic [WIDTH/8-1:0] be,
  input  logic [ADDR-1:0]    addr,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               d_valid,
  output logic               ready
);

  localparam int unsigned   NBYTES = WIDTH / 8;
  localparam logic [ADDR:0] LEN_X  = (ADDR + 1)'(LENGTH);
  localparam logic [ADDR-1:0] LAST = ADDR'(LENGTH - 1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR-1:0]   clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]  instruction_q, instruction_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              ready_q, ready_d;

  logic [WIDTH-1:0]  mem_q [LENGTH];

  logic             accept, i_rd, rd_en, wr_en, clr_en;
  logic             i_in_range, d_in_range;
  logic [WIDTH-1:0] i_word, d_word, wr_word;

  assign accept     = rst_n && (state_q == ST_IDLE);
  assign i_in_range = ({1'b0, i_addr} < LEN_X);
  assign d_in_range = ({1'b0, addr} < LEN_X);
  assign i_rd       = accept && i_req;
  assign rd_en      = accept && CS && !WE;
  assign wr_en      = accept && CS && WE && d_in_range;
  assign clr_en     = rst_n && (state_q == ST_CLEAR);

  // Merged write word is shared by the array update and the write-first bypass.
  always_comb begin
    i_word  = i_in_range ? mem_q[i_addr] : '0;
    d_word  = d_in_range ? mem_q[addr] : '0;
    wr_word = d_word;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (be[k]) wr_word[8*k +: 8] = data_in[8*k +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_RST: begin
        clr_cnt_d = '0;
        state_d   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST) state_d = ST_IDLE;
        else                   clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_IDLE: ;
      default: state_d = ST_RST;
    endcase
    if (!rst_n) begin
      state_d   = ST_RST;
      clr_cnt_d = '0;
    end
  end

  always_comb begin
    instruction_d = instruction_q;
    data_out_d    = data_out_q;
    i_valid_d     = i_rd;
    d_valid_d     = rd_en;
    ready_d       = (state_d == ST_IDLE);
    if (i_rd) begin
      instruction_d = ((WRITE_FIRST != 0) && wr_en && (i_addr == addr)) ? wr_word : i_word;
    end
    if (rd_en) data_out_d = d_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RST;
      clr_cnt_q     <= '0;
      instruction_q <= '0;
      data_out_q    <= '0;
      i_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      instruction_q <= instruction_d;
      data_out_q    <= data_out_d;
      i_valid_q     <= i_valid_d;
      d_valid_q     <= d_valid_d;
      ready_q       <= ready_d;
    end
  end

  // Array has no reset: only the clear sequencer or an accepted write changes it.
  always_ff @(posedge clk) begin
    if (clr_en)     mem_q[clr_cnt_q] <= '0;
    else if (wr_en) mem_q[addr]      <= wr_word;
  end

  assign instruction = instruction_q;
  assign data_out    = data_out_q;
  assign i_valid     = i_valid_q;
  assign d_valid     = d_valid_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_sram_dp.sv
// Bench for sram_dp: three configurations checked every cycle against a
// behavioural memory model, plus literal checks for the directed scenarios.
module tb_sram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Bus A drives u0 (read-first) and u1 (write-first), LENGTH=200.
  logic        rstA = 1'b0, ireqA = 1'b0, csA = 1'b0, weA = 1'b0;
  logic [7:0]  iaddrA = '0, addrA = '0;
  logic [3:0]  beA = '0;
  logic [31:0] dinA = '0;
  // Bus B drives u2: LENGTH=16 with clear-on-reset.
  logic        rstB = 1'b0, ireqB = 1'b0, csB = 1'b0, weB = 1'b0;
  logic [3:0]  iaddrB = '0, addrB = '0;
  logic [3:0]  beB = '0;
  logic [31:0] dinB = '0;

  logic [31:0] ins [3];
  logic [31:0] dout[3];
  logic        iv  [3];
  logic        dv  [3];
  logic        rdy [3];

  sram_dp #(.ADDR(8), .WIDTH(32), .LENGTH(200), .INIT_FILE(""), .CLEAR_ON_RESET(0), .WRITE_FIRST(0)) u0 (
    .clk(clk), .rst_n(rstA), .i_req(ireqA), .i_addr(iaddrA), .instruction(ins[0]), .i_valid(iv[0]),
    .CS(csA), .WE(weA), .be(beA), .addr(addrA), .data_in(dinA), .data_out(dout[0]), .d_valid(dv[0]), .ready(rdy[0]));
  sram_dp #(.ADDR(8), .WIDTH(32), .LENGTH(200), .INIT_FILE(""), .CLEAR_ON_RESET(0), .WRITE_FIRST(1)) u1 (
    .clk(clk), .rst_n(rstA), .i_req(ireqA), .i_addr(iaddrA), .instruction(ins[1]), .i_valid(iv[1]),
    .CS(csA), .WE(weA), .be(beA), .addr(addrA), .data_in(dinA), .data_out(dout[1]), .d_valid(dv[1]), .ready(rdy[1]));
  sram_dp #(.ADDR(4), .WIDTH(32), .LENGTH(16), .INIT_FILE(""), .CLEAR_ON_RESET(1), .WRITE_FIRST(0)) u2 (
    .clk(clk), .rst_n(rstB), .i_req(ireqB), .i_addr(iaddrB), .instruction(ins[2]), .i_valid(iv[2]),
    .CS(csB), .WE(weB), .be(beB), .addr(addrB), .data_in(dinB), .data_out(dout[2]), .d_valid(dv[2]), .ready(rdy[2]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = held in reset, 1 = zero-filling, 2 = serving.
  int          m_len [3] = '{200, 200, 16};
  bit          m_clr [3] = '{1'b0, 1'b0, 1'b1};
  bit          m_wf  [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] mm    [3][256];
  int          phase [3] = '{0, 0, 0};
  int          cnt   [3] = '{0, 0, 0};
  logic [31:0] e_ins [3] = '{0, 0, 0};
  logic [31:0] e_dout[3] = '{0, 0, 0};
  bit          e_iv  [3] = '{0, 0, 0};
  bit          e_dv  [3] = '{0, 0, 0};
  bit          e_rdy [3] = '{0, 0, 0};

  task automatic model_step(input int k, input bit rst, input bit ireq, input int ia,
                            input bit cs, input bit we, input logic [3:0] b, input int wa,
                            input logic [31:0] din);
    logic [31:0] old_i, old_d, merged;
    bit          wr;
    e_iv[k] <= 1'b0;
    e_dv[k] <= 1'b0;
    if (!rst) begin
      phase[k] <= 0;
      e_ins[k] <= '0; e_dout[k] <= '0; e_rdy[k] <= 1'b0;
    end else if (phase[k] == 0) begin
      phase[k] <= m_clr[k] ? 1 : 2;
      cnt[k]   <= 0;
      e_rdy[k] <= !m_clr[k];
    end else if (phase[k] == 1) begin
      mm[k][cnt[k]] <= '0;
      cnt[k]        <= cnt[k] + 1;
      if (cnt[k] == m_len[k] - 1) begin
        phase[k] <= 2;
        e_rdy[k] <= 1'b1;
      end
    end else begin
      old_i  = (ia < m_len[k]) ? mm[k][ia] : 32'h0;
      old_d  = (wa < m_len[k]) ? mm[k][wa] : 32'h0;
      wr     = cs && we && (wa < m_len[k]);
      merged = old_d;
      for (int j = 0; j < 4; j++) if (b[j]) merged[8*j +: 8] = din[8*j +: 8];
      if (ireq) begin
        e_iv[k]  <= 1'b1;
        e_ins[k] <= (m_wf[k] && wr && ia == wa) ? merged : old_i;
      end
      if (cs && !we) begin
        e_dv[k]   <= 1'b1;
        e_dout[k] <= old_d;
      end
      if (wr) mm[k][wa] <= merged;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rstA, ireqA, int'(iaddrA), csA, weA, beA, int'(addrA), dinA);
    model_step(1, rstA, ireqA, int'(iaddrA), csA, weA, beA, int'(addrA), dinA);
    model_step(2, rstB, ireqB, int'(iaddrB), csB, weB, beB, int'(addrB), dinB);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.instruction", k), ins[k], e_ins[k]);
      chk($sformatf("u%0d.i_valid", k), 32'(iv[k]), 32'(e_iv[k]));
      chk($sformatf("u%0d.data_out", k), dout[k], e_dout[k]);
      chk($sformatf("u%0d.d_valid", k), 32'(dv[k]), 32'(e_dv[k]));
      chk($sformatf("u%0d.ready", k), 32'(rdy[k]), 32'(e_rdy[k]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idleA();
    ireqA = 1'b0; csA = 1'b0; weA = 1'b0;
  endtask

  task automatic idleB();
    ireqB = 1'b0; csB = 1'b0; weB = 1'b0;
  endtask

  // Counts edges after release until ready rises; a write is tried mid-clear.
  task automatic wait_ready_B(output int n);
    n = 0;
    do begin
      if (n == 5) begin
        csB = 1'b1; weB = 1'b1; beB = 4'hF; addrB = 4'd2; dinB = 32'h5A5A5A5A;
      end else idleB();
      cyc();
      n++;
    end while (!rdy[2] && n < 100);
    idleB();
    if (n >= 100) chk("u2.ready_timeout", 32'(n), 32'd17);
  endtask

  int n;

  initial begin
    // Reset: outputs must be zero.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst.instruction", ins[0], 32'h0);
      chk("rst.i_valid", 32'(iv[0]), 32'h0);
      chk("rst.data_out", dout[0], 32'h0);
      chk("rst.d_valid", 32'(dv[0]), 32'h0);
      chk("rst.ready", 32'(rdy[0]), 32'h0);
    end
    rstA = 1'b1;
    cyc();
    chk("ready_after_release", 32'(rdy[0]), 32'h1);

    // Preload every in-range word.
    for (int i = 0; i < 200; i++) begin
      csA = 1'b1; weA = 1'b1; beA = 4'hF; addrA = 8'(i);
      dinA = (i == 3) ? 32'h11223344 : (i == 5) ? 32'hDEADBEEF : (i == 7) ? 32'h0 : $urandom;
      cyc();
    end
    idleA();

    ireqA = 1'b1; iaddrA = 8'd5;
    cyc();
    ireqA = 1'b0;
    chk("fetch5.i_valid", 32'(iv[0]), 32'h1);
    chk("fetch5.instruction", ins[0], 32'hDEADBEEF);
    cyc();
    chk("fetch5.i_valid_falls", 32'(iv[0]), 32'h0);
    chk("fetch5.hold", ins[0], 32'hDEADBEEF);

    // Byte-enable write then read.
    csA = 1'b1; weA = 1'b1; beA = 4'b0101; addrA = 8'd3; dinA = 32'hAABBCCDD;
    cyc();
    chk("bewrite.d_valid", 32'(dv[0]), 32'h0);
    weA = 1'b0;
    cyc();
    idleA();
    chk("beread.data_out", dout[0], 32'h11BB33DD);
    chk("beread.d_valid", 32'(dv[0]), 32'h1);
    cyc();
    chk("beread.d_valid_falls", 32'(dv[0]), 32'h0);

    // Collision at addr 7.
    ireqA = 1'b1; iaddrA = 8'd7;
    csA = 1'b1; weA = 1'b1; beA = 4'hF; addrA = 8'd7; dinA = 32'hCAFEF00D;
    cyc();
    idleA();
    chk("collide.read_first", ins[0], 32'h0);
    chk("collide.write_first", ins[1], 32'hCAFEF00D);

    // Out-of-range write then read.
    csA = 1'b1; weA = 1'b1; beA = 4'hF; addrA = 8'd250; dinA = 32'h12345678;
    cyc();
    weA = 1'b0;
    cyc();
    idleA();
    chk("oor.data_out", dout[0], 32'h0);
    chk("oor.d_valid", 32'(dv[0]), 32'h1);

    // Streaming fetch 0..9.
    for (int i = 0; i < 10; i++) begin
      ireqA = 1'b1; iaddrA = 8'(i);
      cyc();
      chk("stream.i_valid", 32'(iv[0]), 32'h1);
      if (i == 3) chk("stream.w3", ins[0], 32'h11BB33DD);
      if (i == 5) chk("stream.w5", ins[0], 32'hDEADBEEF);
      if (i == 7) chk("stream.w7", ins[0], 32'hCAFEF00D);
    end
    idleA();
    cyc();

    // Randomized traffic on bus A, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rstA   = ($urandom_range(0, 99) != 0);
      ireqA  = 1'($urandom_range(0, 1));
      iaddrA = 8'($urandom_range(0, 255));
      csA    = 1'($urandom_range(0, 1));
      weA    = 1'($urandom_range(0, 1));
      beA    = 4'($urandom);
      addrA  = ($urandom_range(0, 3) == 0) ? iaddrA : 8'($urandom_range(0, 255));
      dinA   = $urandom;
      cyc();
    end
    rstA = 1'b1;
    idleA();

    // Clear sequencer.
    cyc();
    rstB = 1'b1;
    wait_ready_B(n);
    chk("clear.ready_edges", 32'(n), 32'd17);
    for (int i = 0; i < 16; i++) begin
      csB = 1'b1; weB = 1'b0; addrB = 4'(i);
      cyc();
      chk("clear.zero", dout[2], 32'h0);
    end
    idleB();

    // Fill nonzero, then reset mid-clear at count 9.
    for (int i = 0; i < 16; i++) begin
      csB = 1'b1; weB = 1'b1; beB = 4'hF; addrB = 4'(i); dinB = 32'hF0000000 | 32'(i + 1);
      cyc();
    end
    idleB();
    rstB = 1'b0;
    cyc();
    cyc();
    rstB = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("midclear.ready_low", 32'(rdy[2]), 32'h0);
    rstB = 1'b0;
    cyc();
    cyc();
    rstB = 1'b1;
    wait_ready_B(n);
    chk("midclear.ready_edges", 32'(n), 32'd17);
    for (int i = 0; i < 16; i++) begin
      ireqB = 1'b1; iaddrB = 4'(15 - i);
      csB = 1'b1; weB = 1'b0; addrB = 4'(i);
      cyc();
      chk("midclear.dzero", dout[2], 32'h0);
      chk("midclear.izero", ins[2], 32'h0);
    end
    idleB();

    // Randomized traffic on bus B, occasionally resetting mid-clear.
    for (int i = 0; i < 1500; i++) begin
      rstB   = ($urandom_range(0, 49) != 0);
      ireqB  = 1'($urandom_range(0, 1));
      iaddrB = 4'($urandom);
      csB    = 1'($urandom_range(0, 1));
      weB    = 1'($urandom_range(0, 1));
      beB    = 4'($urandom);
      addrB  = 4'($urandom);
      dinB   = $urandom;
      cyc();
    end
    idleB();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
